// File: rtl/alu_arbiter.sv
// Shares one RV32IMA ALU between the execute stage (port 0) and the AMO unit (port 1).
// Latency: accept on edge N, ALU evaluates in N+1, response valid from N+2.
// Backpressure: a held response blocks new accepts; a pending request may be accepted in the handshake cycle.

package rv32ima_pkg;
  localparam int BIT_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALUOP_t;
endpackage

module alu_arbiter #(
  parameter int BIT_WIDTH = rv32ima_pkg::BIT_WIDTH,
  parameter int MAX_WAIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // port 0: integer execute stage
  input  logic                   r0_valid,
  output logic                   r0_ready,
  input  rv32ima_pkg::ALUOP_t    r0_op,
  input  logic [BIT_WIDTH-1:0]   r0_in1,
  input  logic [BIT_WIDTH-1:0]   r0_in2,
  output logic                   r0_rsp_valid,
  input  logic                   r0_rsp_ready,
  output logic [BIT_WIDTH-1:0]   r0_out,
  output logic [3:0]             r0_flags,
  // port 1: atomic/AMO unit
  input  logic                   r1_valid,
  output logic                   r1_ready,
  input  rv32ima_pkg::ALUOP_t    r1_op,
  input  logic [BIT_WIDTH-1:0]   r1_in1,
  input  logic [BIT_WIDTH-1:0]   r1_in2,
  output logic                   r1_rsp_valid,
  input  logic                   r1_rsp_ready,
  output logic [BIT_WIDTH-1:0]   r1_out,
  output logic [3:0]             r1_flags,
  // shared ALU
  output rv32ima_pkg::ALUOP_t    alu_op,
  output logic [BIT_WIDTH-1:0]   alu_in1,
  output logic [BIT_WIDTH-1:0]   alu_in2,
  input  logic [BIT_WIDTH-1:0]   alu_out,
  input  logic                   alu_zero,
  input  logic                   alu_neg,
  input  logic                   alu_overflow,
  input  logic                   alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t               state, state_d;
  logic                 owner;
  rv32ima_pkg::ALUOP_t  op_q;
  logic [BIT_WIDTH-1:0] in1_q, in2_q, out_q;
  logic [3:0]           flags_q;
  logic [3:0]           wait_cnt;

  logic grant_vld, grant;
  logic rsp_hs, window, accept;

  // Operands only move on an accept, so the ALU sees stable inputs through EXEC.
  assign alu_op  = op_q;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;

  assign r0_out   = out_q;
  assign r1_out   = out_q;
  assign r0_flags = flags_q;
  assign r1_flags = flags_q;

  // Fixed priority to port 0 unless port 1 has aged out.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (r1_valid && (wait_cnt == MAX_W)) begin
      grant_vld = 1'b1;
      grant     = 1'b1;
    end else if (r0_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b0;
    end else if (r1_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b1;
    end
  end

  // Accept window opens when idle or when the current response is being consumed.
  assign rsp_hs   = (state == RESP) && (owner ? r1_rsp_ready : r0_rsp_ready);
  assign window   = (state == IDLE) || rsp_hs;
  assign accept   = window && grant_vld;
  assign r0_ready = window && grant_vld && !grant;
  assign r1_ready = window && grant_vld && grant;

  // Next-state and response-valid decode.
  always_comb begin
    state_d      = state;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        r0_rsp_valid = !owner;
        r1_rsp_valid = owner;
        if (accept)      state_d = EXEC;
        else if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Latch the winning request and its owner on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      op_q  <= rv32ima_pkg::ALU_ADD;
      in1_q <= '0;
      in2_q <= '0;
    end else if (accept) begin
      owner <= grant;
      op_q  <= grant ? r1_op  : r0_op;
      in1_q <= grant ? r1_in1 : r0_in1;
      in2_q <= grant ? r1_in2 : r0_in2;
    end
  end

  // Capture the ALU result one cycle after the operands were registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (state == EXEC) begin
      out_q   <= alu_out;
      flags_q <= {alu_carry, alu_overflow, alu_neg, alu_zero};
    end
  end

  // Aging counter: cycles port 1 has been valid without acceptance, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!r1_valid || (accept && grant)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Latency: model predicts accept at edge N and response from N+2.
// Backpressure: random rsp_ready stalls; requesters hold requests until accepted.

module tb_alu_arbiter;
  import rv32ima_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  ALUOP_t      r0_op;
  logic [31:0] r0_in1, r0_in2, r0_out;
  logic [3:0]  r0_flags;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  ALUOP_t      r1_op;
  logic [31:0] r1_in1, r1_in2, r1_out;
  logic [3:0]  r1_flags;
  ALUOP_t      alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        alu_zero, alu_neg, alu_overflow, alu_carry;

  int n_checks = 0;
  int n_pass   = 0;

  // transaction-level model
  bit          m_busy  = 1'b0;
  int          m_age   = 0;
  bit          m_owner = 1'b0;
  int          m_wait  = 0;
  ALUOP_t      m_op    = ALU_ADD;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  logic [35:0] m_res   = '0;
  int          acc_log[$];

  always #5 clk = ~clk;

  alu_arbiter #(.BIT_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_in1(r0_in1), .r0_in2(r0_in2),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_out(r0_out), .r0_flags(r0_flags),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_in1(r1_in1), .r1_in2(r1_in2),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_out(r1_out), .r1_flags(r1_flags),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_overflow(alu_overflow), .alu_carry(alu_carry)
  );

  // Returns {carry, overflow, neg, zero, result}.
  function automatic logic [35:0] ref_alu(ALUOP_t op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    logic [31:0] o;
    logic        c, v;
    s = '0; o = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b}; o = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (o[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b}; o = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (o[31] != a[31]);
      end
      ALU_AND: o = a & b;
      ALU_OR:  o = a | b;
      ALU_XOR: o = a ^ b;
      default: o = '0;
    endcase
    return {c, v, o[31], (o == 32'd0), o};
  endfunction

  // The external ALU seen by the arbiter.
  always_comb begin
    {alu_carry, alu_overflow, alu_neg, alu_zero, alu_out} = ref_alu(alu_op, alu_in1, alu_in2);
  end

  function automatic ALUOP_t rand_op();
    return ALUOP_t'($urandom_range(0, 4));
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic int m_grant();
    if (r1_valid && (m_wait >= MW)) return 1;
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_window();
    if (!m_busy) return 1'b1;
    return (m_age >= 2) && (m_owner ? r1_rsp_ready : r0_rsp_ready);
  endfunction

  function automatic bit exp_ready(int p);
    return m_window() && (m_grant() == p);
  endfunction

  function automatic bit exp_rsp(int p);
    return m_busy && (m_age >= 2) && (int'(m_owner) == p);
  endfunction

  // Advance one clock and update the model from the inputs presented before the edge.
  task automatic tick();
    int          g;
    bit          win, hs, v1;
    ALUOP_t      op;
    logic [31:0] a, b;
    g   = m_grant();
    win = m_window();
    hs  = m_busy && (m_age >= 2) && (m_owner ? r1_rsp_ready : r0_rsp_ready);
    v1  = r1_valid;
    op  = (g == 1) ? r1_op  : r0_op;
    a   = (g == 1) ? r1_in1 : r0_in1;
    b   = (g == 1) ? r1_in2 : r0_in2;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_owner = 1'b0; m_wait = 0; m_age = 0;
      m_op = ALU_ADD; m_a = '0; m_b = '0; m_res = '0;
    end else begin
      if (win && g >= 0) begin
        m_owner = (g == 1); m_op = op; m_a = a; m_b = b;
        m_res = ref_alu(op, a, b); m_busy = 1'b1; m_age = 1;
        acc_log.push_back(g);
      end else if (hs) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
      if ((win && g == 1) || !v1) m_wait = 0;
      else if (m_wait < MW)       m_wait++;
    end
    #1;
  endtask

  task automatic drain();
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0_valid = 1'b0; r0_op = ALU_SUB; r0_in1 = 32'h1234; r0_in2 = 32'h55;
    r1_valid = 1'b0; r1_op = ALU_XOR; r1_in1 = 32'h9; r1_in2 = 32'h3;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL reset_r0_rsp_valid: got %b want 0", r0_rsp_valid); else n_pass++;
    n_checks++; if (r1_rsp_valid !== 1'b0) $display("FAIL reset_r1_rsp_valid: got %b want 0", r1_rsp_valid); else n_pass++;
    n_checks++; if (alu_op !== ALU_ADD) $display("FAIL reset_alu_op: got %0d want %0d", alu_op, ALU_ADD); else n_pass++;
    n_checks++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0) $display("FAIL reset_alu_in: got %h/%h want 0/0", alu_in1, alu_in2); else n_pass++;
    n_checks++; if (r0_out !== 32'd0 || r0_flags !== 4'd0) $display("FAIL reset_out_flags: got %h/%b want 0/0000", r0_out, r0_flags); else n_pass++;
    n_checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) $display("FAIL reset_ready_idle: got %b%b want 00", r0_ready, r1_ready); else n_pass++;
    r0_valid = 1'b1; #1;
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL reset_r0_ready_comb: got %b want 1", r0_ready); else n_pass++;
    r0_valid = 1'b0; r1_valid = 1'b1; #1;
    n_checks++; if (r1_ready !== 1'b1) $display("FAIL reset_r1_ready_comb: got %b want 1", r1_ready); else n_pass++;
    r1_valid = 1'b0;
    tick();
  endtask

  task automatic test_port0_add();
    r0_valid = 1'b1; r0_op = ALU_ADD; r0_in1 = 32'h0000_0005; r0_in2 = 32'h0000_0003;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL add0_ready: got %b want 1", r0_ready); else n_pass++;
    tick();
    r0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL add0_rsp_early: got %b want 0", r0_rsp_valid); else n_pass++;
    n_checks++; if (alu_op !== ALU_ADD || alu_in1 !== 32'd5 || alu_in2 !== 32'd3) $display("FAIL add0_alu_drive: got %0d %h %h want 0 5 3", alu_op, alu_in1, alu_in2); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b1) $display("FAIL add0_rsp_valid: got %b want 1", r0_rsp_valid); else n_pass++;
    n_checks++; if (r0_out !== 32'h8) $display("FAIL add0_out: got %h want 00000008", r0_out); else n_pass++;
    n_checks++; if (r0_flags !== 4'b0000) $display("FAIL add0_flags: got %b want 0000", r0_flags); else n_pass++;
    n_checks++; if (r1_rsp_valid !== 1'b0) $display("FAIL add0_r1_rsp: got %b want 0", r1_rsp_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL add0_rsp_drop: got %b want 0", r0_rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_port1_arith();
    ALUOP_t      t_op[2];
    logic [31:0] t_a[2], t_b[2], t_o[2];
    logic [3:0]  t_m[2];
    t_op = '{ALU_SUB, ALU_ADD};
    t_a  = '{32'h0, 32'h7FFF_FFFF};
    t_b  = '{32'h1, 32'h1};
    t_o  = '{32'hFFFF_FFFF, 32'h8000_0000};
    t_m  = '{4'b0010, 4'b0110};
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r1_valid = 1'b1; r1_op = t_op[i]; r1_in1 = t_a[i]; r1_in2 = t_b[i];
      @(negedge clk);
      n_checks++; if (r1_ready !== 1'b1) $display("FAIL p1_ready[%0d]: got %b want 1", i, r1_ready); else n_pass++;
      tick();
      r1_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      n_checks++; if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0) $display("FAIL p1_rsp_valid[%0d]: got %b%b want 10", i, r1_rsp_valid, r0_rsp_valid); else n_pass++;
      n_checks++; if (r1_out !== t_o[i]) $display("FAIL p1_out[%0d]: got %h want %h", i, r1_out, t_o[i]); else n_pass++;
      n_checks++; if ((r1_flags & t_m[i]) !== t_m[i]) $display("FAIL p1_flags[%0d]: got %b want bits %b set", i, r1_flags, t_m[i]); else n_pass++;
      tick();
    end
    tick();
  endtask

  task automatic test_aging();
    int n0;
    acc_log.delete();
    r0_valid = 1'b1; r0_op = rand_op(); r0_in1 = rand_opnd(); r0_in2 = rand_opnd();
    r1_valid = 1'b1; r1_op = rand_op(); r1_in1 = rand_opnd(); r1_in2 = rand_opnd();
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    for (int c = 0; c < 40 && acc_log.size() < 12; c++) begin
      @(negedge clk);
      n_checks++; if (r0_ready !== exp_ready(0) || r1_ready !== exp_ready(1)) $display("FAIL aging_ready c%0d: got %b%b want %b%b", c, r0_ready, r1_ready, exp_ready(0), exp_ready(1)); else n_pass++;
      if (exp_rsp(0) || exp_rsp(1)) begin
        n_checks++; if (r0_out !== m_res[31:0] || r0_flags !== m_res[35:32]) $display("FAIL aging_data c%0d: got %h/%b want %h/%b", c, r0_out, r0_flags, m_res[31:0], m_res[35:32]); else n_pass++;
      end
      n0 = acc_log.size();
      tick();
      if (acc_log.size() > n0) begin
        if (acc_log[$] == 0) begin r0_op = rand_op(); r0_in1 = rand_opnd(); r0_in2 = rand_opnd(); end
        else                 begin r1_op = rand_op(); r1_in1 = rand_opnd(); r1_in2 = rand_opnd(); end
      end
    end
    n_checks++; if (acc_log.size() < 12) $display("FAIL aging_accept_count: got %0d want 12", acc_log.size()); else n_pass++;
    for (int i = 0; i < 12 && i < acc_log.size(); i++) begin
      n_checks++; if (acc_log[i] != ((i % 3 == 2) ? 1 : 0)) $display("FAIL aging_order[%0d]: got port %0d want port %0d", i, acc_log[i], (i % 3 == 2) ? 1 : 0); else n_pass++;
    end
    drain();
  endtask

  task automatic test_stall();
    logic [35:0] exp;
    r0_valid = 1'b1; r0_op = ALU_XOR; r0_in1 = $urandom; r0_in2 = $urandom;
    r1_valid = 1'b1; r1_op = rand_op(); r1_in1 = rand_opnd(); r1_in2 = rand_opnd();
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b1;
    exp = ref_alu(r0_op, r0_in1, r0_in2);
    @(negedge clk);
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL stall_first_ready: got %b want 1", r0_ready); else n_pass++;
    tick();
    r0_op = ALU_AND; r0_in1 = $urandom; r0_in2 = $urandom;
    @(negedge clk);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (r0_rsp_valid !== 1'b1) $display("FAIL stall_rsp_valid[%0d]: got %b want 1", k, r0_rsp_valid); else n_pass++;
      n_checks++; if (r0_out !== exp[31:0] || r0_flags !== exp[35:32]) $display("FAIL stall_hold[%0d]: got %h/%b want %h/%b", k, r0_out, r0_flags, exp[31:0], exp[35:32]); else n_pass++;
      n_checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b%b want 00", k, r0_ready, r1_ready); else n_pass++;
      tick();
    end
    r0_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b1 || r1_ready !== 1'b1 || r0_ready !== 1'b0) $display("FAIL stall_release: got rsp%b rdy%b%b want rsp1 rdy01", r0_rsp_valid, r0_ready, r1_ready); else n_pass++;
    exp = ref_alu(r1_op, r1_in1, r1_in2);
    tick();
    r1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++; if (r1_rsp_valid !== 1'b1 || r1_out !== exp[31:0]) $display("FAIL stall_p1_result: got %b/%h want 1/%h", r1_rsp_valid, r1_out, exp[31:0]); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_reset_exec();
    logic [35:0] exp;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_op = ALU_SUB; r0_in1 = $urandom | 32'h1; r0_in2 = $urandom;
    r1_valid = 1'b1; r1_op = rand_op(); r1_in1 = rand_opnd(); r1_in2 = rand_opnd();
    @(negedge clk);
    n_checks++; if (r0_ready !== 1'b1) $display("FAIL rstx_accept: got %b want 1", r0_ready); else n_pass++;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) $display("FAIL rstx_rsp_in_reset[%0d]: got %b%b want 00", k, r0_rsp_valid, r1_rsp_valid); else n_pass++;
      end
      tick();
    end
    rst = 1'b0;
    r0_op = ALU_ADD; r0_in1 = $urandom; r0_in2 = $urandom;
    exp = ref_alu(r0_op, r0_in1, r0_in2);
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) $display("FAIL rstx_no_rsp: got %b%b want 00", r0_rsp_valid, r1_rsp_valid); else n_pass++;
    n_checks++; if (alu_op !== ALU_ADD || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) $display("FAIL rstx_alu_cleared: got %0d %h %h want 0 0 0", alu_op, alu_in1, alu_in2); else n_pass++;
    n_checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) $display("FAIL rstx_wait_cleared: got %b%b want 10", r0_ready, r1_ready); else n_pass++;
    tick();
    r0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL rstx_exec_rsp: got %b want 0", r0_rsp_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (r0_rsp_valid !== 1'b1 || r0_out !== exp[31:0] || r0_flags !== exp[35:32]) $display("FAIL rstx_after: got %b %h/%b want 1 %h/%b", r0_rsp_valid, r0_out, r0_flags, exp[31:0], exp[35:32]); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp_q[$];
    logic [35:0] e;
    int          nrsp, last;
    bit          acc;
    nrsp = 0; last = -1;
    r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_op = rand_op(); r0_in1 = rand_opnd(); r0_in2 = rand_opnd();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (r0_rsp_valid === 1'b1) begin
        nrsp++;
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL b2b_unexpected_rsp c%0d: got response want none", c);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (r0_out !== e[31:0] || r0_flags !== e[35:32]) $display("FAIL b2b_data c%0d: got %h/%b want %h/%b", c, r0_out, r0_flags, e[31:0], e[35:32]); else n_pass++;
        end
        if (last >= 0) begin
          n_checks++; if (c - last != 2) $display("FAIL b2b_spacing c%0d: got %0d want 2", c, c - last); else n_pass++;
        end
        last = c;
      end
      acc = r0_valid && (r0_ready === 1'b1);
      if (acc) exp_q.push_back(ref_alu(r0_op, r0_in1, r0_in2));
      tick();
      if (acc) begin r0_op = rand_op(); r0_in1 = rand_opnd(); r0_in2 = rand_opnd(); end
    end
    n_checks++; if (nrsp != 7) $display("FAIL b2b_count: got %0d want 7", nrsp); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    bit h0, h1, e0, e1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e0 = exp_ready(0); e1 = exp_ready(1);
      n_checks++; if (r0_ready !== e0 || r1_ready !== e1) $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, r0_ready, r1_ready, e0, e1); else n_pass++;
      n_checks++; if (r0_rsp_valid !== exp_rsp(0) || r1_rsp_valid !== exp_rsp(1)) $display("FAIL rnd_rsp_valid c%0d: got %b%b want %b%b", c, r0_rsp_valid, r1_rsp_valid, exp_rsp(0), exp_rsp(1)); else n_pass++;
      n_checks++; if (alu_op !== m_op || alu_in1 !== m_a || alu_in2 !== m_b) $display("FAIL rnd_alu_drive c%0d: got %0d %h %h want %0d %h %h", c, alu_op, alu_in1, alu_in2, m_op, m_a, m_b); else n_pass++;
      if (exp_rsp(0)) begin
        n_checks++; if (r0_out !== m_res[31:0] || r0_flags !== m_res[35:32]) $display("FAIL rnd_r0_data c%0d: got %h/%b want %h/%b", c, r0_out, r0_flags, m_res[31:0], m_res[35:32]); else n_pass++;
      end
      if (exp_rsp(1)) begin
        n_checks++; if (r1_out !== m_res[31:0] || r1_flags !== m_res[35:32]) $display("FAIL rnd_r1_data c%0d: got %h/%b want %h/%b", c, r1_out, r1_flags, m_res[31:0], m_res[35:32]); else n_pass++;
      end
      h0 = r0_valid && !e0;
      h1 = r1_valid && !e1;
      tick();
      if (!h0) begin
        r0_valid = ($urandom_range(0, 2) != 0);
        r0_op = rand_op(); r0_in1 = rand_opnd(); r0_in2 = rand_opnd();
      end
      if (!h1) begin
        r1_valid = ($urandom_range(0, 2) != 0);
        r1_op = rand_op(); r1_in1 = rand_opnd(); r1_in2 = rand_opnd();
      end
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_port0_add();
    test_port1_arith();
    test_aging();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single RV32IMA ALU between two requesters: the integer execute stage (port 0) and the atomic/AMO unit (port 1). Each port uses a valid/ready request channel and a valid/ready response channel. The block registers the winning operation, drives the ALU interface signals (op, in1, in2), captures out and flags one cycle later, and returns them to the owner. Port 0 has fixed priority, and an aging counter bounds how long port 1 can be starved.

## Interface
Parameters
- BIT_WIDTH, 32: operand width; equals rv32ima_pkg::BIT_WIDTH.
- MAX_WAIT, 4: number of cycles port 1 may be blocked while valid before it takes priority (1..15).

Ports (x = 0, 1)
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  request x valid.
- rx_ready  out  1  request x accepted this cycle when high together with rx_valid.
- rx_op  in  ALUOP_t  ALU operation for request x.
- rx_in1, rx_in2  in  BIT_WIDTH  operands for request x.
- rx_rsp_valid  out  1  response x valid.
- rx_rsp_ready  in  1  requester x consumes the response.
- rx_out  out  BIT_WIDTH  result.
- rx_flags  out  4  {carry, overflow, neg, zero}.
- alu_op  out  ALUOP_t  to the ALU.
- alu_in1, alu_in2  out  BIT_WIDTH  to the ALU.
- alu_out  in  BIT_WIDTH  from the ALU.
- alu_zero, alu_neg, alu_overflow, alu_carry  in  1  from the ALU.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers:
  - owner (1 bit)
  - op_q, in1_q, in2_q
  - out_q, flags_q
  - wait_cnt (4 bits)
- alu_op, alu_in1 and alu_in2 are driven from op_q, in1_q and in2_q at all times, so ALU inputs change only on an accept.
- Grant (combinational):
  - If wait_cnt == MAX_WAIT and r1_valid: grant = 1.
  - Else if r0_valid: grant = 0.
  - Else if r1_valid: grant = 1.
  - Else: no grant.
- Accept window (open):
  - state == IDLE, or
  - state == RESP and the owner's rsp_valid && rsp_ready handshake completes this cycle.
- rx_ready = accept window open && grant == x. A ready never depends on the same port's rx_valid except through grant.
- Accept:
  - Latch op, in1, in2 and owner = grant.
  - Next state is EXEC.
- Any state other than EXEC, with no accept:
  - RESP with handshake complete goes to IDLE.
  - Otherwise the state holds.
- EXEC:
  - out_q <= alu_out.
  - flags_q <= {alu_carry, alu_overflow, alu_neg, alu_zero}.
  - Next state is RESP, unconditionally.
- RESP:
  - r[owner]_rsp_valid = 1; the other port's rsp_valid = 0.
  - rx_out and rx_flags show out_q and flags_q on both ports; they are meaningful only with rsp_valid.
  - Hold until r[owner]_rsp_ready.
- wait_cnt:
  - Reset to 0 on a port-1 accept or when r1_valid is low.
  - Otherwise increment each cycle r1_valid is high and not accepted, saturating at MAX_WAIT.
- Requesters hold rx_op and operands stable while rx_valid is high and not accepted. The arbiter does not check this.
- Reset:
  - State goes to IDLE. Any in-flight operation is discarded with no response.
  - All rx_rsp_valid = 0.
  - op_q = ALU_ADD; in1_q, in2_q, out_q, flags_q = 0.
  - owner = 0; wait_cnt = 0.
  - rx_ready is high after reset only through grant, i.e. combinationally in IDLE.

## Timing
- Latency: accept on edge N, EXEC in cycle N+1, rsp_valid high in cycle N+2.
- Back-to-back throughput: one operation per 2 cycles when rsp_ready is high in the first RESP cycle and the next request is already valid.
- Response stall: rsp_valid, rx_out and rx_flags hold stable while rsp_ready is low.
- Simultaneous r0_valid and r1_valid with wait_cnt < MAX_WAIT: port 0 wins and port 1's counter advances.
- Aging bound with MAX_WAIT = 4: after at most 4 cycles blocked, port 1 wins the next accept window.
- Saturation: wait_cnt does not wrap.

## Test plan
- Single op on port 0 (add, 0x0000_0005 + 0x0000_0003), accepted at edge N -> r0_rsp_valid at N+2, r0_out = 0x8, flags = 0000. r1_rsp_valid stays 0.
- Port 1 subtract (0x0 - 0x1) -> r1_out = 0xFFFF_FFFF, neg = 1. With add 0x7FFF_FFFF + 0x1 -> overflow = 1, neg = 1.
- Both ports continuously valid, rsp_ready always 1, MAX_WAIT = 4:
  - Port 0 takes the first grants.
  - Port 1 is granted once its wait_cnt reaches 4.
  - Then port 0 again. Grant sequence repeats, and port 1 never waits more than 4 cycles while blocked.
- r0_rsp_ready low for 5 cycles -> r0_out and flags stable, r0_ready and r1_ready both 0 throughout. Deassert-to-accept: a pending request is accepted in the same cycle as the response handshake.
- rst asserted in EXEC -> next cycle IDLE, no rsp_valid ever, alu_op = ALU_ADD, wait_cnt = 0. A following request completes normally.
- Back-to-back port 0 ops with rsp_ready tied high -> responses every 2 cycles, results in order.
